matrix_capture: RTL and testbench
=================================

MATRIX_CAPTURE -- requirements
Module: matrix_capture

Interface
REQ-001 Parameter ROWFIX, default 1: when 1, the stored row index is the decoded row XOR 1, matching the v01 dot-matrix row-pair swap.
REQ-002 clk  input  1  system clock, 12 MHz; every input is sampled in this domain.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rclk, rsdi  input  1 each  row shift-register clock and serial data; the active row is marked by the single 0 bit.
REQ-005 cclk, csdi  input  1 each  column shift-register clock and serial data (1 = LED lit).
REQ-006 le, oeb  input  1 each  column latch enable; output-enable (active-low).
REQ-007 rd_row  input  4  framebuffer read row index.
REQ-008 rd_data  output  16  framebuffer row rd_row; bit c = column c.
REQ-009 line_valid  output  1  one-cycle pulse, one row was captured.
REQ-010 line_row, line_data  output  4, 16  row and column data of the last captured line.
REQ-011 frame_done  output  1  one-cycle pulse, row 15 was captured.
REQ-012 frame_cnt  output  8  count of completed frames, wraps 255 -> 0.
REQ-013 row_err  output  1  sticky flag: a latch occurred while the row selection was invalid.

Function
REQ-014 All inputs except rd_row SHALL be registered once; a rising edge is an input sampled 1 while its registered copy is 0.
REQ-015 On a cclk rising edge: colsr <= {colsr[14:0], csdi}. After 16 shifts, column 0 is in colsr[15] (column c in bit 15-c).
REQ-016 On an rclk rising edge: rowsr <= {rowsr[14:0], rsdi}.
REQ-017 On an le rising edge the block SHALL use the pre-shift values of colsr and rowsr, even if cclk or rclk rise in the same cycle.
REQ-018 Row decode: rowsr is valid only if exactly one bit is 0; the decoded row r is the index of that bit, and the stored row is r XOR ROWFIX.
REQ-019 Valid row and oeb=0 at the le edge: the bit-reversed colsr SHALL be written to frame[row], line_row/line_data updated, and line_valid pulsed in the next cycle.
REQ-020 Valid row and oeb=1: the line SHALL be discarded, with no write and no pulse.
REQ-021 Invalid row: the line SHALL be discarded, and row_err set to 1 and held until reset.
REQ-022 frame_done SHALL pulse in the same cycle as a line_valid whose line_row is 15; frame_cnt increments in that same cycle.
REQ-023 rd_data SHALL be registered with 1-cycle latency; reading a row written in the same cycle returns the old contents.

Reset
REQ-024 While reset=0: colsr = 0, rowsr = 16'hFFFF, framebuffer all 0.
REQ-025 While reset=0: line_valid, frame_done, row_err, frame_cnt, line_row, line_data and rd_data are all 0, and the registered inputs are 0.
REQ-026 A reset in the middle of a line SHALL discard the partial shift contents; no write or pulse occurs for that line.

Structure
REQ-027 A shared package SHALL hold constant MATRIX_DIM = 16 and the row-index and row-data widths (4 and 16).
REQ-028 One sub-module, rise_detect (a registered input plus edge pulse), SHALL be instantiated once for each of rclk, cclk and le.

Verification
REQ-029 Shift 16 column bits 1,0,0,... for row 0 (rsdi=0 on the first rclk), then le -> line_valid=1, line_row=1 (ROWFIX=1), line_data=16'h0001.
REQ-030 Drive a full 16-line frame with column c lit in row c -> one frame_done pulse and frame_cnt=1; rd_row=5 yields rd_data=16'h0010 one cycle later (row 5 stored at index 4).
REQ-031 Pulse le with rowsr=16'hFFFF immediately after reset -> no line_valid, row_err=1, which stays set through further valid lines.
REQ-032 Capture a line with oeb=1 -> no line_valid, and the framebuffer row is unchanged.
REQ-033 Rising edges of cclk and le in the same cycle -> the latched data excludes that cycle's csdi bit.
REQ-034 Drive reset=0 after 8 column shifts, then complete 16 shifts plus le -> the captured data contains only the post-reset bits, and frame_cnt=0.

Source files
------------

// File: rtl/matrix_capture_pkg.sv
// Shared constants, types and helpers for the dot-matrix line capture block.
package matrix_capture_pkg;

    localparam int MATRIX_DIM = 16;
    localparam int ROW_W      = 4;
    localparam int DATA_W     = 16;
    localparam int CNT_W      = 8;

    typedef logic [ROW_W-1:0]  row_idx_t;
    typedef logic [DATA_W-1:0] row_data_t;
    typedef logic [CNT_W-1:0]  frame_cnt_t;

    typedef struct packed {
        logic     valid;
        row_idx_t idx;
    } row_sel_t;

    // A row selection is only meaningful when exactly one driver bit is low.
    function automatic row_sel_t decode_row(input row_data_t sr);
        row_sel_t sel;
        int       zeros;
        sel   = '0;
        zeros = 0;
        for (int i = 0; i < MATRIX_DIM; i++) begin
            if (!sr[i]) begin
                zeros   = zeros + 1;
                sel.idx = row_idx_t'(i);
            end
        end
        sel.valid = (zeros == 1);
        return sel;
    endfunction

    function automatic row_data_t bit_reverse(input row_data_t v);
        row_data_t r;
        for (int i = 0; i < MATRIX_DIM; i++) begin
            r[i] = v[MATRIX_DIM-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/matrix_capture_rise_detect.sv
// Registers one asynchronous control input and flags its 0->1 transition.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic sync_q;
    logic sync_d;
    logic prev_q;
    logic prev_d;

    always_comb begin
        sync_d = d;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/matrix_capture.sv
// Snoops the row/column shift-register bus of a 16x16 LED matrix and rebuilds
// the displayed image in a local framebuffer, one latched line at a time.
module matrix_capture
    import matrix_capture_pkg::*;
#(
    parameter bit ROWFIX = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rclk,
    input  logic              rsdi,
    input  logic              cclk,
    input  logic              csdi,
    input  logic              le,
    input  logic              oeb,
    input  logic [ROW_W-1:0]  rd_row,
    output logic [DATA_W-1:0] rd_data,
    output logic              line_valid,
    output logic [ROW_W-1:0]  line_row,
    output logic [DATA_W-1:0] line_data,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              row_err
);

    logic rclk_rise;
    logic cclk_rise;
    logic le_rise;

    rise_detect u_rclk (.clk(clk), .reset(reset), .d(rclk), .rise(rclk_rise));
    rise_detect u_cclk (.clk(clk), .reset(reset), .d(cclk), .rise(cclk_rise));
    rise_detect u_le   (.clk(clk), .reset(reset), .d(le),   .rise(le_rise));

    logic       rsdi_q, rsdi_d;
    logic       csdi_q, csdi_d;
    logic       oeb_q,  oeb_d;
    row_data_t  colsr_q, colsr_d;
    row_data_t  rowsr_q, rowsr_d;
    row_data_t  frame_q [MATRIX_DIM];
    row_data_t  frame_d [MATRIX_DIM];
    row_data_t  rd_data_q, rd_data_d;
    logic       line_valid_q, line_valid_d;
    row_idx_t   line_row_q, line_row_d;
    row_data_t  line_data_q, line_data_d;
    logic       frame_done_q, frame_done_d;
    frame_cnt_t frame_cnt_q, frame_cnt_d;
    logic       row_err_q, row_err_d;

    row_sel_t   sel;
    row_idx_t   wr_row;
    row_data_t  wr_data;

    // The latch decision reads the _q shift registers, so a shift in the same
    // cycle as le never leaks into the captured line.
    always_comb begin
        rsdi_d       = rsdi;
        csdi_d       = csdi;
        oeb_d        = oeb;
        colsr_d      = colsr_q;
        rowsr_d      = rowsr_q;
        frame_d      = frame_q;
        rd_data_d    = frame_q[rd_row];
        line_valid_d = 1'b0;
        line_row_d   = line_row_q;
        line_data_d  = line_data_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        row_err_d    = row_err_q;
        sel          = decode_row(rowsr_q);
        wr_row       = sel.idx ^ row_idx_t'(ROWFIX);
        wr_data      = bit_reverse(colsr_q);

        if (cclk_rise) begin
            colsr_d = {colsr_q[DATA_W-2:0], csdi_q};
        end
        if (rclk_rise) begin
            rowsr_d = {rowsr_q[DATA_W-2:0], rsdi_q};
        end

        if (le_rise) begin
            if (!sel.valid) begin
                row_err_d = 1'b1;
            end else if (!oeb_q) begin
                frame_d[wr_row] = wr_data;
                line_valid_d    = 1'b1;
                line_row_d      = wr_row;
                line_data_d     = wr_data;
                if (wr_row == row_idx_t'(MATRIX_DIM - 1)) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsdi_q       <= 1'b0;
            csdi_q       <= 1'b0;
            oeb_q        <= 1'b0;
            colsr_q      <= '0;
            rowsr_q      <= '1;
            frame_q      <= '{default: '0};
            rd_data_q    <= '0;
            line_valid_q <= 1'b0;
            line_row_q   <= '0;
            line_data_q  <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            row_err_q    <= 1'b0;
        end else begin
            rsdi_q       <= rsdi_d;
            csdi_q       <= csdi_d;
            oeb_q        <= oeb_d;
            colsr_q      <= colsr_d;
            rowsr_q      <= rowsr_d;
            frame_q      <= frame_d;
            rd_data_q    <= rd_data_d;
            line_valid_q <= line_valid_d;
            line_row_q   <= line_row_d;
            line_data_q  <= line_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            row_err_q    <= row_err_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign line_valid = line_valid_q;
    assign line_row   = line_row_q;
    assign line_data  = line_data_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign row_err    = row_err_q;

endmodule

// File: tb/tb_matrix_capture.sv
// Directed self-checking bench for matrix_capture: drives the LED shift bus
// by hand and compares captured lines and framebuffer reads to known values.
module tb_matrix_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rclk = 1'b0;
    logic        rsdi = 1'b1;
    logic        cclk = 1'b0;
    logic        csdi = 1'b0;
    logic        le = 1'b0;
    logic        oeb = 1'b0;
    logic [3:0]  rd_row = 4'd0;
    logic [15:0] rd_data;
    logic        line_valid;
    logic [3:0]  line_row;
    logic [15:0] line_data;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        row_err;

    always #5 clk = ~clk;

    matrix_capture #(.ROWFIX(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .rclk       (rclk),
        .rsdi       (rsdi),
        .cclk       (cclk),
        .csdi       (csdi),
        .le         (le),
        .oeb        (oeb),
        .rd_row     (rd_row),
        .rd_data    (rd_data),
        .line_valid (line_valid),
        .line_row   (line_row),
        .line_data  (line_data),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .row_err    (row_err)
    );

    int compared = 0;
    int mismatched = 0;
    int lv_count = 0;
    int fd_count = 0;
    int fd_misplaced = 0;
    logic [3:0]  last_row = 4'd0;
    logic [15:0] last_data = 16'd0;

    // Every cycle with line_valid high counts, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (line_valid === 1'b1) begin
            lv_count  = lv_count + 1;
            last_row  = line_row;
            last_data = line_data;
        end
        if (frame_done === 1'b1) begin
            fd_count = fd_count + 1;
            if (!(line_valid === 1'b1 && line_row === 4'd15)) fd_misplaced = fd_misplaced + 1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_col(input logic b);
        csdi = b;
        cycles(2);
        cclk = 1'b1;
        cycles(3);
        cclk = 1'b0;
        cycles(3);
    endtask

    task automatic shift_row(input logic b);
        rsdi = b;
        cycles(2);
        rclk = 1'b1;
        cycles(3);
        rclk = 1'b0;
        cycles(3);
    endtask

    // Bit k of pat is the k-th bit shifted, which lands in column k.
    task automatic shift_cols(input logic [15:0] pat);
        for (int k = 0; k < 16; k++) shift_col(pat[k]);
    endtask

    task automatic pulse_le();
        le = 1'b1;
        cycles(3);
        le = 1'b0;
        cycles(4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(3);
        reset = 1'b1;
        cycles(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(2);
        compared++; if (line_valid !== 1'b0) begin mismatched++; $display("FAIL reset_line_valid: got %b, expected 0", line_valid); end
        compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_frame_done: got %b, expected 0", frame_done); end
        compared++; if (row_err !== 1'b0) begin mismatched++; $display("FAIL reset_row_err: got %b, expected 0", row_err); end
        compared++; if (frame_cnt !== 8'd0) begin mismatched++; $display("FAIL reset_frame_cnt: got %0d, expected 0", frame_cnt); end
        compared++; if (line_row !== 4'd0) begin mismatched++; $display("FAIL reset_line_row: got %0d, expected 0", line_row); end
        compared++; if (line_data !== 16'h0000) begin mismatched++; $display("FAIL reset_line_data: got %h, expected 0000", line_data); end
        compared++; if (rd_data !== 16'h0000) begin mismatched++; $display("FAIL reset_rd_data: got %h, expected 0000", rd_data); end
        reset = 1'b1;
        cycles(2);
    endtask

    task automatic test_invalid_row();
        lv_count = 0;
        pulse_le();
        compared++; if (lv_count !== 0) begin mismatched++; $display("FAIL invalid_no_line: got %0d pulses, expected 0", lv_count); end
        compared++; if (row_err !== 1'b1) begin mismatched++; $display("FAIL invalid_row_err: got %b, expected 1", row_err); end
    endtask

    task automatic test_single_line();
        lv_count = 0;
        shift_cols(16'h0001);
        shift_row(1'b0);
        pulse_le();
        compared++; if (lv_count !== 1) begin mismatched++; $display("FAIL single_pulse: got %0d pulses, expected 1", lv_count); end
        compared++; if (last_row !== 4'd1) begin mismatched++; $display("FAIL single_row: got %0d, expected 1", last_row); end
        compared++; if (last_data !== 16'h0001) begin mismatched++; $display("FAIL single_data: got %h, expected 0001", last_data); end
        compared++; if (row_err !== 1'b1) begin mismatched++; $display("FAIL sticky_row_err: got %b, expected 1", row_err); end
    endtask

    task automatic test_full_frame();
        logic [15:0] onehot;
        do_reset();
        lv_count = 0;
        fd_count = 0;
        fd_misplaced = 0;
        for (int c = 0; c < 16; c++) begin
            onehot = 16'h0001 << c;
            shift_cols(onehot);
            shift_row(c == 0 ? 1'b0 : 1'b1);
            pulse_le();
        end
        compared++; if (lv_count !== 16) begin mismatched++; $display("FAIL frame_lines: got %0d pulses, expected 16", lv_count); end
        compared++; if (fd_count !== 1) begin mismatched++; $display("FAIL frame_done_count: got %0d, expected 1", fd_count); end
        compared++; if (fd_misplaced !== 0) begin mismatched++; $display("FAIL frame_done_align: got %0d stray pulses, expected 0", fd_misplaced); end
        compared++; if (frame_cnt !== 8'd1) begin mismatched++; $display("FAIL frame_cnt: got %0d, expected 1", frame_cnt); end
        rd_row = 4'd4;
        cycles(2);
        compared++; if (rd_data !== 16'h0020) begin mismatched++; $display("FAIL read_row4: got %h, expected 0020", rd_data); end
        rd_row = 4'd5;
        compared++; if (rd_data !== 16'h0020) begin mismatched++; $display("FAIL read_latency: got %h, expected 0020 before the edge", rd_data); end
        @(posedge clk);
        #1;
        compared++; if (rd_data !== 16'h0010) begin mismatched++; $display("FAIL read_row5: got %h, expected 0010", rd_data); end
        cycles(1);
        rd_row = 4'd0;
        cycles(2);
        compared++; if (rd_data !== 16'h0002) begin mismatched++; $display("FAIL read_row0: got %h, expected 0002", rd_data); end
    endtask

    task automatic test_oeb_discard();
        lv_count = 0;
        oeb = 1'b1;
        shift_cols(16'hFFFF);
        pulse_le();
        oeb = 1'b0;
        compared++; if (lv_count !== 0) begin mismatched++; $display("FAIL oeb_no_line: got %0d pulses, expected 0", lv_count); end
        rd_row = 4'd14;
        cycles(2);
        compared++; if (rd_data !== 16'h8000) begin mismatched++; $display("FAIL oeb_row_kept: got %h, expected 8000", rd_data); end
        compared++; if (frame_cnt !== 8'd1) begin mismatched++; $display("FAIL oeb_frame_cnt: got %0d, expected 1", frame_cnt); end
    endtask

    task automatic test_same_cycle();
        lv_count = 0;
        shift_cols(16'h0005);
        csdi = 1'b1;
        cycles(2);
        cclk = 1'b1;
        le = 1'b1;
        cycles(3);
        cclk = 1'b0;
        le = 1'b0;
        cycles(4);
        compared++; if (lv_count !== 1) begin mismatched++; $display("FAIL same_pulse: got %0d pulses, expected 1", lv_count); end
        compared++; if (last_row !== 4'd14) begin mismatched++; $display("FAIL same_row: got %0d, expected 14", last_row); end
        compared++; if (last_data !== 16'h0005) begin mismatched++; $display("FAIL same_data: got %h, expected 0005", last_data); end
    endtask

    task automatic test_reset_mid_line();
        lv_count = 0;
        for (int k = 0; k < 8; k++) shift_col(1'b1);
        do_reset();
        shift_row(1'b0);
        shift_col(1'b1);
        for (int k = 0; k < 7; k++) shift_col(1'b0);
        pulse_le();
        compared++; if (lv_count !== 1) begin mismatched++; $display("FAIL midreset_pulse: got %0d pulses, expected 1", lv_count); end
        compared++; if (last_row !== 4'd1) begin mismatched++; $display("FAIL midreset_row: got %0d, expected 1", last_row); end
        compared++; if (last_data !== 16'h0100) begin mismatched++; $display("FAIL midreset_data: got %h, expected 0100", last_data); end
        compared++; if (frame_cnt !== 8'd0) begin mismatched++; $display("FAIL midreset_frame_cnt: got %0d, expected 0", frame_cnt); end
    endtask

    initial begin
        $display("[TB] matrix_capture directed bench starting");
        test_reset();
        test_invalid_row();
        test_single_line();
        test_full_frame();
        test_oeb_discard();
        test_same_cycle();
        test_reset_mid_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
